// File: rtl/load_extend_unit.sv
// Load-data lane extractor and sign/zero extender with a two-stage valid/ready pipeline.
// S1 captures the addressed lane right-aligned; S2 extends it to the full datapath width.
module load_extend_unit #(
    parameter  int DATA_WIDTH = 32,
    localparam int OFFW       = $clog2(DATA_WIDTH / 8)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [OFFW-1:0]       in_offset,
    input  logic [1:0]            in_size,
    input  logic                  in_unsigned,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err,
    input  logic                  err_clr,
    output logic                  err_sticky
);

    // Access size in bits (8, 16, 32 or 64).
    function automatic int size_bits(input logic [1:0] size);
        return int'(32'd8 << size);
    endfunction

    function automatic logic size_legal(input logic [1:0] size);
        return size_bits(size) <= DATA_WIDTH;
    endfunction

    // Low offset bits that must be zero for a naturally aligned access.
    function automatic logic [OFFW-1:0] align_mask(input logic [1:0] size);
        logic [OFFW-1:0] m;
        case (size)
            2'd0:    m = OFFW'(3'd0);
            2'd1:    m = OFFW'(3'd1);
            2'd2:    m = OFFW'(3'd3);
            2'd3:    m = OFFW'(3'd7);
            default: m = OFFW'(3'd0);
        endcase
        return m;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [1:0] size);
        logic [DATA_WIDTH-1:0] m;
        int                    bits;
        bits = size_bits(size);
        m    = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            m[i] = (i < bits);
        end
        return m;
    endfunction

    // Replicate the field MSB (or zero) above the field; full-width fields pass unchanged.
    function automatic logic [DATA_WIDTH-1:0] extend(
        input logic [DATA_WIDTH-1:0] field,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic [DATA_WIDTH-1:0] r;
        logic                  msb;
        int                    bits;
        bits = size_bits(size);
        msb  = 1'b0;
        r    = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i == bits - 1) begin
                msb = field[i];
            end else begin
                msb = msb;
            end
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < bits) begin
                r[i] = field[i];
            end else begin
                r[i] = uns ? 1'b0 : msb;
            end
        end
        return r;
    endfunction

    logic                  s1_valid_q,  s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_field_q,  s1_field_d;
    logic [1:0]            s1_size_q,   s1_size_d;
    logic                  s1_uns_q,    s1_uns_d;
    logic                  s1_err_q,    s1_err_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic                  out_err_q,   out_err_d;
    logic                  sticky_q,    sticky_d;

    logic                  s2_free_s;
    logic                  s1_adv_s;
    logic                  in_fire_s;
    logic                  out_fire_s;
    logic                  req_err_s;
    logic [DATA_WIDTH-1:0] shifted_s;

    // Handshake and pipeline-advance decode.
    always_comb begin
        s2_free_s  = !out_valid_q || out_ready;
        s1_adv_s   = s1_valid_q && s2_free_s;
        in_ready   = rst_n && (!s1_valid_q || s2_free_s);
        in_fire_s  = in_valid && in_ready;
        out_fire_s = out_valid_q && out_ready;
        req_err_s  = (|(in_offset & align_mask(in_size))) || !size_legal(in_size);
        shifted_s  = in_data >> {in_offset, 3'b000};
    end

    // S1 next state: capture the right-aligned lane, zeroed for errored requests.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_field_d = s1_field_q;
        s1_size_d  = s1_size_q;
        s1_uns_d   = s1_uns_q;
        s1_err_d   = s1_err_q;
        if (in_fire_s) begin
            s1_valid_d = 1'b1;
            s1_size_d  = in_size;
            s1_uns_d   = in_unsigned;
            s1_err_d   = req_err_s;
            if (req_err_s) begin
                s1_field_d = '0;
            end else begin
                s1_field_d = shifted_s & lane_mask(in_size);
            end
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S2 next state: load the extended result when S1 advances, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        if (s1_adv_s) begin
            out_valid_d = 1'b1;
            out_err_d   = s1_err_q;
            if (s1_err_q) begin
                out_data_d = '0;
            end else begin
                out_data_d = extend(s1_field_q, s1_size_q, s1_uns_q);
            end
        end else if (out_fire_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Sticky error flag: a handed-off error takes priority over a clear.
    always_comb begin
        sticky_d = sticky_q;
        if (out_fire_s && out_err_q) begin
            sticky_d = 1'b1;
        end else if (err_clr) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_field_q  <= '0;
            s1_size_q   <= 2'd0;
            s1_uns_q    <= 1'b0;
            s1_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_field_q  <= s1_field_d;
            s1_size_q   <= s1_size_d;
            s1_uns_q    <= s1_uns_d;
            s1_err_q    <= s1_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_load_extend_unit.sv
// Scoreboard bench for load_extend_unit: a 32-bit instance driven through a queue-based
// reference model, plus a 64-bit instance for the doubleword cases.
module tb_load_extend_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, in_unsigned;
    logic [31:0] in_data;
    logic [1:0]  in_offset, in_size;
    logic        out_valid, out_ready, out_err, err_clr, err_sticky;
    logic [31:0] out_data;

    logic        v64, r64, uns64, ov64, ordy64, oerr64, clr64, sticky64;
    logic [63:0] d64, od64;
    logic [2:0]  off64;
    logic [1:0]  sz64;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_acc   = 0;
    int          n_out   = 0;
    logic        acc_last;
    logic [32:0] sb[$];

    load_extend_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_offset(in_offset), .in_size(in_size),
        .in_unsigned(in_unsigned), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .err_clr(err_clr), .err_sticky(err_sticky)
    );

    load_extend_unit #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(r64),
        .in_data(d64), .in_offset(off64), .in_size(sz64),
        .in_unsigned(uns64), .out_valid(ov64), .out_ready(ordy64),
        .out_data(od64), .out_err(oerr64), .err_clr(clr64), .err_sticky(sticky64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model for 32-bit width: {err, data}.
    function automatic logic [32:0] model32(input logic [31:0] d, input logic [1:0] off,
                                            input logic [1:0] sz, input logic uns);
        int          nbytes;
        int          nbits;
        logic [31:0] f;
        nbytes = 1 << sz;
        nbits  = 8 * nbytes;
        if ((int'(off) % nbytes) != 0 || nbits > 32) return {1'b1, 32'h0};
        f = d >> (8 * off);
        if (nbits < 32) begin
            f = f << (32 - nbits);
            if (uns) f = f >> (32 - nbits);
            else     f = $signed(f) >>> (32 - nbits);
        end
        return {1'b0, f};
    endfunction

    // One clock: record the transfers that happen at the coming edge, then advance.
    task automatic step();
        logic [32:0] e;
        #1;
        acc_last = in_valid && in_ready;
        if (acc_last) begin
            sb.push_back(model32(in_data, in_offset, in_size, in_unsigned));
            n_acc++;
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                chk("sb_unexpected_output", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_data", {32'd0, out_data}, {32'd0, e[31:0]});
                chk("sb_err", {63'd0, out_err}, {63'd0, e[32]});
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                        input logic uns);
        bit done;
        done        = 1'b0;
        in_valid    = 1'b1;
        in_data     = d;
        in_offset   = off;
        in_size     = sz;
        in_unsigned = uns;
        for (int k = 0; k < 50 && !done; k++) begin
            step();
            done = acc_last;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < 40 && (sb.size() != 0 || out_valid); k++) step();
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // 64-bit instance: one request, result checked after the second edge.
    task automatic run64(input logic [63:0] d, input logic [2:0] off, input logic [1:0] sz,
                         input logic uns, input logic [63:0] exp, input string tag);
        v64 = 1'b1; d64 = d; off64 = off; sz64 = sz; uns64 = uns; ordy64 = 1'b1;
        @(negedge clk);
        v64 = 1'b0;
        @(negedge clk);
        chk({tag, "_valid"}, {63'd0, ov64}, 64'd1);
        chk({tag, "_data"}, od64, exp);
        chk({tag, "_err"}, {63'd0, oerr64}, 64'd0);
        @(negedge clk);
    endtask

    logic [31:0] bp_data[5];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_offset = 2'd0; in_size = 2'd0;
        in_unsigned = 1'b0; out_ready = 1'b1; err_clr = 1'b0; acc_last = 1'b0;
        v64 = 1'b0; d64 = 64'd0; off64 = 3'd0; sz64 = 2'd0; uns64 = 1'b0; ordy64 = 1'b1;
        clr64 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_sticky", {63'd0, err_sticky}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);

        // Signed byte: latency and value checked against constants as well as the model.
        send(32'h12AB34F0, 2'd2, 2'd0, 1'b0);
        chk("lat_edge_n", {63'd0, out_valid}, 64'd0);
        step();
        chk("lat_edge_n1", {63'd0, out_valid}, 64'd1);
        chk("sbyte_data", {32'd0, out_data}, 64'h0000_0000_FFFF_FFAB);
        drain();
        send(32'h12AB34F0, 2'd2, 2'd0, 1'b1);
        step();
        chk("ubyte_data", {32'd0, out_data}, 64'h0000_0000_0000_00AB);
        drain();
        send(32'h80017FFE, 2'd2, 2'd1, 1'b0);
        step();
        chk("shalf_hi", {32'd0, out_data}, 64'h0000_0000_FFFF_8001);
        drain();
        send(32'h80017FFE, 2'd0, 2'd1, 1'b0);
        send(32'h80017FFE, 2'd0, 2'd2, 1'b0);
        send(32'h80017FFE, 2'd0, 2'd2, 1'b1);
        drain();

        // Errors and sticky flag.
        send(32'hDEADBEEF, 2'd1, 2'd1, 1'b0);
        step();
        chk("mis_err", {63'd0, out_err}, 64'd1);
        chk("mis_data", {32'd0, out_data}, 64'd0);
        drain();
        chk("sticky_set", {63'd0, err_sticky}, 64'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("sticky_clr", {63'd0, err_sticky}, 64'd0);
        send(32'hCAFEF00D, 2'd0, 2'd3, 1'b0);
        step();
        chk("dword_err32", {63'd0, out_err}, 64'd1);
        err_clr = 1'b1;
        drain();
        err_clr = 1'b0;
        chk("sticky_set_wins", {63'd0, err_sticky}, 64'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Backpressure: five requests with the consumer stalled.
        for (int i = 0; i < 5; i++) bp_data[i] = 32'h1000_0001 * (i + 3);
        out_ready = 1'b0;
        n_out     = 0;
        begin
            int idx;
            idx = 0;
            for (int k = 0; k < 20 && idx < 2; k++) begin
                in_valid = 1'b1; in_data = bp_data[idx]; in_offset = 2'd0;
                in_size = 2'(idx % 3); in_unsigned = idx[0];
                step();
                if (acc_last) idx++;
            end
            #1;
            chk("bp_ready_low", {63'd0, in_ready}, 64'd0);
            for (int k = 0; k < 3; k++) begin
                step();
                chk("bp_no_accept", {63'd0, acc_last}, 64'd0);
                chk("bp_stable", {32'd0, out_data}, {32'd0, sb[0][31:0]});
            end
            out_ready = 1'b1;
            #1;
            chk("bp_ready_comb", {63'd0, in_ready}, 64'd1);
            for (int k = 0; k < 30 && idx < 5; k++) begin
                in_valid = 1'b1; in_data = bp_data[idx]; in_offset = 2'd0;
                in_size = 2'(idx % 3); in_unsigned = idx[0];
                step();
                if (acc_last) idx++;
            end
            drain();
            chk("bp_count", 64'(n_out), 64'd5);
        end

        // Random traffic against the model queue.
        begin
            int sent;
            sent  = 0;
            n_out = 0;
            for (int k = 0; k < 20000 && sent < 1000; k++) begin
                in_valid    = ($urandom_range(0, 3) != 0);
                in_data     = $urandom;
                in_offset   = 2'($urandom_range(0, 3));
                in_size     = 2'($urandom_range(0, 3));
                in_unsigned = 1'($urandom_range(0, 1));
                out_ready   = ($urandom_range(0, 2) != 0);
                step();
                if (acc_last) sent++;
            end
            drain();
            chk("rand_sent", 64'(sent), 64'd1000);
            chk("rand_out", 64'(n_out), 64'd1000);
        end

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        send(32'h11223344, 2'd0, 2'd0, 1'b0);
        send(32'h55667788, 2'd0, 2'd1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_out_data", {32'd0, out_data}, 64'd0);
        chk("midrst_in_ready2", {63'd0, in_ready}, 64'd0);
        sb.delete();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("postrst_ready", {63'd0, in_ready}, 64'd1);
        chk("postrst_valid", {63'd0, out_valid}, 64'd0);
        for (int k = 0; k < 4; k++) step();
        send(32'h0000F0F0, 2'd0, 2'd1, 1'b0);
        step();
        chk("postrst_data", {32'd0, out_data}, 64'h0000_0000_FFFF_F0F0);
        drain();

        // 64-bit width cases.
        run64(64'h8000_0000_0000_0001, 3'd4, 2'd2, 1'b0, 64'hFFFF_FFFF_8000_0000, "w64_word");
        run64(64'h8000_0000_0000_0001, 3'd0, 2'd3, 1'b0, 64'h8000_0000_0000_0001, "w64_dword");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
